// File: rtl/fft_result_serializer.sv
// Captures one parallel FFT frame into a buffer and streams it out one complex
// word per cycle over valid/ready, optionally in bit-reversed element order.
module fft_result_serializer #(
  parameter int N      = 32,
  parameter int LOG2N  = 5,
  parameter int DW     = 19,
  parameter int BITREV = 0
) (
  input  logic             clk_p_i,
  input  logic             reset_n_i,
  input  logic [N*DW-1:0]  frame_r_i,
  input  logic [N*DW-1:0]  frame_i_i,
  input  logic             frame_valid_i,
  output logic             frame_ready_o,
  output logic [DW-1:0]    out_r_o,
  output logic [DW-1:0]    out_i_o,
  output logic [LOG2N-1:0] out_idx_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_last_o,
  output logic             frame_done_o,
  output logic             overflow_o,
  input  logic             ovf_clr_i,
  output logic             dbg_state_o
);

  // Output handshake: a word moves on a rising edge where out_valid_o and
  // out_ready_i are both high; a frame is taken when frame_valid_i and
  // frame_ready_o are both high, otherwise the strobe is dropped and flagged.

  typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LOG2N-1:0]  r_idx;
  logic [2*DW-1:0]   r_buf [N];
  logic [DW-1:0]     r_out_r;
  logic [DW-1:0]     r_out_i;
  logic              r_done;
  logic              r_ovf;

  logic              w_xfer;
  logic              w_at_last;
  logic              w_ready;
  logic              w_capture;
  logic              w_drop;
  logic [LOG2N-1:0]  w_next_addr;

  function automatic logic [LOG2N-1:0] rd_addr(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    r = k;
    if (BITREV != 0) begin
      for (int b = 0; b < LOG2N; b++) r[b] = k[LOG2N-1-b];
    end
    return r;
  endfunction

  assign w_xfer      = (r_state == S_STREAM) & out_ready_i;
  assign w_at_last   = (r_idx == LOG2N'(N-1));
  assign w_ready     = (r_state == S_IDLE) | (w_xfer & w_at_last);
  assign w_capture   = frame_valid_i & w_ready;
  assign w_drop      = frame_valid_i & ~w_ready;
  assign w_next_addr = rd_addr(r_idx + 1'b1);

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_capture) w_state_nxt = S_STREAM;
      S_STREAM: if (w_xfer && w_at_last && !w_capture) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Buffer has no reset: its contents only matter after a capture.
  always_ff @(posedge clk_p_i) begin
    if (w_capture) begin
      for (int j = 0; j < N; j++) begin
        r_buf[j] <= {frame_r_i[j*DW +: DW], frame_i_i[j*DW +: DW]};
      end
    end
  end

  // Output word is registered: loaded straight from the frame on capture
  // (element 0 in either read order), then from the buffer on each transfer.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_idx   <= '0;
      r_out_r <= '0;
      r_out_i <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_xfer & w_at_last;
      if (w_capture) begin
        r_idx   <= '0;
        r_out_r <= frame_r_i[0 +: DW];
        r_out_i <= frame_i_i[0 +: DW];
      end else if (w_xfer) begin
        if (w_at_last) begin
          r_idx <= '0;
        end else begin
          r_idx   <= r_idx + 1'b1;
          r_out_r <= r_buf[w_next_addr][2*DW-1:DW];
          r_out_i <= r_buf[w_next_addr][DW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i)     r_ovf <= 1'b0;
    else if (w_drop)    r_ovf <= 1'b1;
    else if (ovf_clr_i) r_ovf <= 1'b0;
  end

  assign frame_ready_o = w_ready;
  assign out_valid_o   = (r_state == S_STREAM);
  assign out_last_o    = (r_state == S_STREAM) & w_at_last;
  assign out_idx_o     = r_idx;
  assign out_r_o       = r_out_r;
  assign out_i_o       = r_out_i;
  assign frame_done_o  = r_done;
  assign overflow_o    = r_ovf;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_fft_result_serializer.sv
// Bench for fft_result_serializer: natural-order and bit-reversed instances share
// stimulus; a negedge monitor checks each presented word against expected queues.
module tb_fft_result_serializer;
  localparam int N     = 32;
  localparam int LOG2N = 5;
  localparam int DW    = 19;
  localparam int EW    = 1 + LOG2N + 2*DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [N*DW-1:0]   frame_r, frame_i;
  logic              frame_valid, out_ready, ovf_clr;

  logic              frame_ready, out_valid, out_last, frame_done, overflow, dbg_state;
  logic [DW-1:0]     out_r, out_i;
  logic [LOG2N-1:0]  out_idx;
  logic              frame_ready_b, out_valid_b, out_last_b, frame_done_b, overflow_b, dbg_state_b;
  logic [DW-1:0]     out_r_b, out_i_b;
  logic [LOG2N-1:0]  out_idx_b;

  fft_result_serializer #(.N(N), .LOG2N(LOG2N), .DW(DW), .BITREV(0)) dut (
    .clk_p_i(clk), .reset_n_i(reset_n), .frame_r_i(frame_r), .frame_i_i(frame_i),
    .frame_valid_i(frame_valid), .frame_ready_o(frame_ready), .out_r_o(out_r),
    .out_i_o(out_i), .out_idx_o(out_idx), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_last_o(out_last), .frame_done_o(frame_done),
    .overflow_o(overflow), .ovf_clr_i(ovf_clr), .dbg_state_o(dbg_state));

  fft_result_serializer #(.N(N), .LOG2N(LOG2N), .DW(DW), .BITREV(1)) dut_br (
    .clk_p_i(clk), .reset_n_i(reset_n), .frame_r_i(frame_r), .frame_i_i(frame_i),
    .frame_valid_i(frame_valid), .frame_ready_o(frame_ready_b), .out_r_o(out_r_b),
    .out_i_o(out_i_b), .out_idx_o(out_idx_b), .out_valid_o(out_valid_b),
    .out_ready_i(out_ready), .out_last_o(out_last_b), .frame_done_o(frame_done_b),
    .overflow_o(overflow_b), .ovf_clr_i(ovf_clr), .dbg_state_o(dbg_state_b));

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_br_q[$];
  logic [DW-1:0] fr_r [N];
  logic [DW-1:0] fr_i [N];

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0, done_cnt_b = 0, xfer_cnt = 0, xfer_cnt_b = 0;
  int done_exp = 0;
  int xfer_base;
  logic prev_last = 1'b0, prev_last_b = 1'b0;
  int pat [4] = '{1, 0, 0, 1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) r[b] = k[LOG2N-1-b];
    return r;
  endfunction

  // kind 0: real=j, imag=0x7FFFF-j; kind 1: second frame; kind 2: frame to be dropped
  task automatic load_frame(input int kind);
    for (int j = 0; j < N; j++) begin
      case (kind)
        0:       begin fr_r[j] = DW'(j);            fr_i[j] = DW'(19'h7FFFF - j); end
        1:       begin fr_r[j] = DW'(19'h40000 + j); fr_i[j] = DW'(19'h3FFFF - j); end
        default: begin fr_r[j] = DW'(19'h2AAAA + j); fr_i[j] = DW'(19'h15555 + j); end
      endcase
    end
  endtask

  task automatic push_exp();
    for (int k = 0; k < N; k++) begin
      logic [LOG2N-1:0] kk;
      kk = LOG2N'(k);
      exp_q.push_back({(k == N-1), kk, fr_r[k], fr_i[k]});
      exp_br_q.push_back({(k == N-1), kk, fr_r[bitrev(kk)], fr_i[bitrev(kk)]});
    end
  endtask

  task automatic strobe();
    for (int j = 0; j < N; j++) begin
      frame_r[j*DW +: DW] = fr_r[j];
      frame_i[j*DW +: DW] = fr_i[j];
    end
    frame_valid = 1'b1;
    @(posedge clk); #1;
    frame_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 600; c++) begin
      if (exp_q.size() == 0 && exp_br_q.size() == 0 && !out_valid && !out_valid_b) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    n_checks++; n_errors++;
    $display("FAIL %s: timeout waiting for stream end, %0d words pending", name, exp_q.size());
  endtask

  task automatic wait_idx(input logic [LOG2N-1:0] k);
    for (int c = 0; c < 200; c++) begin
      if (out_valid && out_idx == k) return;
      @(posedge clk); #1;
    end
    n_checks++; n_errors++;
    $display("FAIL wait_idx: timeout waiting for k=%0d got none", k);
  endtask

  // Monitor: compares each presented word, pops on transfer, checks done timing.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_last   = 1'b0;
      prev_last_b = 1'b0;
    end else begin
      check("frame_done", frame_done, prev_last);
      check("frame_done_br", frame_done_b, prev_last_b);
      if (frame_done)   done_cnt++;
      if (frame_done_b) done_cnt_b++;
      prev_last   = 1'b0;
      prev_last_b = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL word: got unexpected k=%0d r=%0h expected no word", out_idx, out_r);
        end else begin
          check("word", {out_last, out_idx, out_r, out_i}, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            xfer_cnt++;
            prev_last = out_last;
          end
        end
      end
      if (out_valid_b) begin
        if (exp_br_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL word_br: got unexpected k=%0d r=%0h expected no word", out_idx_b, out_r_b);
        end else begin
          check("word_br", {out_last_b, out_idx_b, out_r_b, out_i_b}, exp_br_q[0]);
          if (out_ready) begin
            void'(exp_br_q.pop_front());
            xfer_cnt_b++;
            prev_last_b = out_last_b;
          end
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; frame_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    frame_r = '0; frame_i = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_i", out_i, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_state", dbg_state, 0);
    #21 reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_frame_ready", frame_ready, 1);
    check("rst_frame_ready_br", frame_ready_b, 1);

    // Basic frame
    xfer_base = xfer_cnt;
    load_frame(0); push_exp(); strobe();
    check("capture_latency", out_valid, 1);
    check("stream_state", dbg_state, 1);
    check("capture_ready_low", frame_ready, 0);
    wait_idle("basic");
    done_exp = 1;
    check("basic_xfers", xfer_cnt - xfer_base, 32);
    check("basic_done_cnt", done_cnt, done_exp);
    check("basic_done_cnt_br", done_cnt_b, done_exp);
    check("basic_ready_after", frame_ready, 1);

    // Backpressure 1,0,0,1
    xfer_base = xfer_cnt;
    load_frame(0); push_exp(); strobe();
    for (int c = 0; c < 400; c++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      out_ready = pat[c % 4][0];
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle("backpressure");
    done_exp = 2;
    check("bp_xfers", xfer_cnt - xfer_base, 32);
    check("bp_done_cnt", done_cnt, done_exp);

    // Back-to-back: second frame strobed on the last transfer of the first
    xfer_base = xfer_cnt;
    load_frame(0); push_exp(); strobe();
    wait_idx(5'd31);
    check("b2b_ready_on_last", frame_ready, 1);
    load_frame(1); push_exp(); strobe();
    check("b2b_no_bubble_valid", out_valid, 1);
    check("b2b_no_bubble_idx", out_idx, 0);
    check("b2b_first_real", out_r, 19'h40000);
    wait_idle("b2b");
    done_exp = 4;
    check("b2b_xfers", xfer_cnt - xfer_base, 64);
    check("b2b_done_cnt", done_cnt, done_exp);
    check("b2b_overflow", overflow, 0);

    // Overflow: strobe at k=10 is dropped
    load_frame(0); push_exp(); strobe();
    wait_idx(5'd10);
    load_frame(2); strobe();
    check("ovf_set", overflow, 1);
    check("ovf_set_br", overflow_b, 1);
    wait_idle("overflow");
    done_exp = 5;
    check("ovf_done_cnt", done_cnt, done_exp);
    check("ovf_sticky", overflow, 1);
    ovf_clr = 1'b1; @(posedge clk); #1; ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Clear and new overflow in the same cycle: set wins
    load_frame(0); push_exp(); strobe();
    wait_idx(5'd3);
    load_frame(2); ovf_clr = 1'b1; strobe(); ovf_clr = 1'b0;
    check("ovf_set_wins", overflow, 1);
    wait_idle("ovf_set_wins");
    done_exp = 6;
    check("ovf2_done_cnt", done_cnt, done_exp);
    ovf_clr = 1'b1; @(posedge clk); #1; ovf_clr = 1'b0;
    check("ovf2_cleared", overflow, 0);

    // Async reset mid-stream at k=5
    load_frame(0); push_exp(); strobe();
    wait_idx(5'd5);
    #2 reset_n = 1'b0;
    exp_q.delete(); exp_br_q.delete();
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_valid_br", out_valid_b, 0);
    check("arst_idx", out_idx, 0);
    check("arst_out_r", out_r, 0);
    check("arst_done", frame_done, 0);
    @(posedge clk); #3 reset_n = 1'b1;
    #1;
    check("arst_ready", frame_ready, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("arst_no_done", done_cnt, done_exp);
    xfer_base = xfer_cnt;
    load_frame(1); push_exp(); strobe();
    check("arst_fresh_idx", out_idx, 0);
    wait_idle("arst_fresh");
    done_exp = 7;
    check("arst_fresh_xfers", xfer_cnt - xfer_base, 32);
    check("arst_fresh_done", done_cnt, done_exp);
    check("final_done_br", done_cnt_b, done_exp);
    check("final_xfers_br", xfer_cnt_b, xfer_cnt);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
